// File: rtl/irq_ctrl_sb.sv
// rtl/irq_ctrl_sb.sv - bus-slave interrupt controller: edge-latched pending, enable mask, priority arbitration
// Optional rotating priority selected by defining IRQ_ROUND_ROBIN_EN.
module irq_ctrl_sb #(
    parameter int N_SRC = 8,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    input  logic [N_SRC-1:0] irq_i,
    output logic [N_SRC-1:0] irq_ret_o,
    output logic             irq_req_o,
    input  logic             irq_ret_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] prev_irq_q;
    logic [ID_W-1:0]  active_id_q, active_id_d;
    logic             irq_req_q, irq_req_d;
    logic [N_SRC-1:0] irq_ret_q, irq_ret_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             soft_rst_q, soft_rst_d;
`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]  last_id_q, last_id_d;
`endif

    logic             bus_wr, bus_rd;
    logic [29:0]      word_addr;
    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] edges;
    logic [ID_W-1:0]  win_id;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];

    assign bus_wr    = req_i & write_enable_i;
    assign bus_rd    = req_i & ~write_enable_i;
    assign word_addr = addr_i[31:2];
    assign masked    = pending_q & enable_q;
    assign edges     = irq_i & ~prev_irq_q;

    // Winner selection: rotating search starts just above the last serviced id.
    always_comb begin
`ifdef IRQ_ROUND_ROBIN_EN
        int best;
        int dist;
        best   = N_SRC;
        win_id = '0;
        for (int i = 0; i < N_SRC; i++) begin
            dist = (i + N_SRC - int'(last_id_q) - 1) % N_SRC;
            if (masked[i] && dist < best) begin
                best   = dist;
                win_id = ID_W'(i);
            end
        end
`else
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) win_id = ID_W'(i);
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        enable_d    = enable_q;
        active_id_d = active_id_q;
        irq_req_d   = irq_req_q;
        irq_ret_d   = '0;
        read_data_d = read_data_q;
        soft_rst_d  = bus_wr && (word_addr == 30'd9) && (write_data_i == 32'd1);
`ifdef IRQ_ROUND_ROBIN_EN
        last_id_d   = last_id_q;
`endif

        if (bus_wr && word_addr == 30'd0) pending_d = pending_d & ~write_data_i[N_SRC-1:0];
        if (bus_wr && word_addr == 30'd1) enable_d = write_data_i[N_SRC-1:0];

        if (bus_rd) begin
            case (word_addr)
                30'd0:   read_data_d = {{(32 - N_SRC){1'b0}}, pending_q};
                30'd1:   read_data_d = {{(32 - N_SRC){1'b0}}, enable_q};
                30'd2:   read_data_d = {state_q == ACTIVE, {(31 - ID_W){1'b0}}, active_id_q};
                default: read_data_d = 32'd0;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (|masked) begin
                    active_id_d = win_id;
                    for (int i = 0; i < N_SRC; i++) begin
                        if (win_id == ID_W'(i)) pending_d[i] = 1'b0;
                    end
                    irq_req_d = 1'b1;
                    state_d   = ACTIVE;
`ifdef IRQ_ROUND_ROBIN_EN
                    last_id_d = win_id;
`endif
                end
            end
            ACTIVE: begin
                if (irq_ret_i) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        irq_ret_d[i] = (active_id_q == ID_W'(i));
                    end
                    irq_req_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh edge outranks any clear issued in the same cycle.
        pending_d = pending_d | edges;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_rst_q) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            enable_q    <= '0;
            prev_irq_q  <= '0;
            active_id_q <= '0;
            irq_req_q   <= 1'b0;
            irq_ret_q   <= '0;
            read_data_q <= 32'd0;
            soft_rst_q  <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
            last_id_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            prev_irq_q  <= irq_i;
            active_id_q <= active_id_d;
            irq_req_q   <= irq_req_d;
            irq_ret_q   <= irq_ret_d;
            read_data_q <= read_data_d;
            soft_rst_q  <= soft_rst_d;
`ifdef IRQ_ROUND_ROBIN_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign read_data_o = read_data_q;
    assign irq_req_o   = irq_req_q;
    assign irq_ret_o   = irq_ret_q;

endmodule

// File: tb/tb_irq_ctrl_sb.sv
// tb/tb_irq_ctrl_sb.sv - scoreboard bench for irq_ctrl_sb with randomized interrupt bursts
module tb_irq_ctrl_sb;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_i, req_i, write_enable_i, irq_ret_i;
    logic [31:0]   addr_i, write_data_i, read_data_o;
    logic [N-1:0]  irq_i, irq_ret_o;
    logic          irq_req_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];
    int model_last = 0;
    int mon_id;

    irq_ctrl_sb #(.N_SRC(N)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .write_enable_i(write_enable_i),
        .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o),
        .irq_i(irq_i), .irq_ret_o(irq_ret_o), .irq_req_o(irq_req_o), .irq_ret_i(irq_ret_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every return pulse must match the next expected serviced source.
    always @(negedge clk) begin
        if (irq_ret_o !== '0) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_irq_ret: got 0x%02h expected none", irq_ret_o);
            end else begin
                mon_id = exp_q.pop_front();
                check("irq_ret_o", {24'd0, irq_ret_o}, 32'd1 << mon_id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
        tick();
        req_i = 1'b0; write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
        tick();
        req_i = 1'b0;
        d = read_data_o;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Reference model: service order of a simultaneous burst, from the priority rule alone.
    task automatic push_order(input int mask);
`ifdef IRQ_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (model_last + k) % N;
            if (mask[idx]) begin
                exp_q.push_back(idx);
                model_last = idx;
            end
        end
`else
        for (int i = 0; i < N; i++) if (mask[i]) exp_q.push_back(i);
`endif
    endtask

    task automatic pulse_irq(input logic [N-1:0] m);
        irq_i = m;
        tick();
        irq_i = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (irq_req_o !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total_cnt++;
        if (irq_req_o === 1'b1) pass_cnt++;
        else $display("FAIL wait_irq_req: got %b expected 1 within 10 cycles", irq_req_o);
    endtask

    task automatic service_one();
        logic [31:0] exp_cause;
        wait_req();
        exp_cause = (exp_q.size() > 0) ? (32'h8000_0000 | 32'(exp_q[0])) : 32'hFFFF_FFFF;
        read_check("cause", 32'h08, exp_cause);
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        check("gap_irq_req", {31'd0, irq_req_o}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] en, set, serv;
        rst_i = 1'b1; req_i = 1'b0; write_enable_i = 1'b0; addr_i = '0;
        write_data_i = '0; irq_i = '0; irq_ret_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_read_data", read_data_o, 32'd0);
        check("rst_irq_req", {31'd0, irq_req_o}, 32'd0);
        read_check("rst_enable", 32'h04, 32'd0);
        read_check("rst_cause", 32'h08, 32'd0);
        read_check("rst_pending", 32'h00, 32'd0);
        bus_write(32'h10, 32'hDEAD_BEEF);
        read_check("unmapped", 32'h10, 32'd0);

        // Latency: edge -> pending -> irq_req.
        bus_write(32'h04, 32'h05);
        irq_i = 8'h04;
        push_order(32'h04);
        tick();
        irq_i = '0;
        check("lat_edge1", {31'd0, irq_req_o}, 32'd0);
        tick();
        check("lat_edge2", {31'd0, irq_req_o}, 32'd1);
        service_one();
        tick();
        check("idle_irq_req", {31'd0, irq_req_o}, 32'd0);

        // Disabled source stays pending until enabled.
        bus_write(32'h04, 32'h00);
        pulse_irq(8'h02);
        read_check("pend_disabled", 32'h00, 32'h02);
        check("no_req_disabled", {31'd0, irq_req_o}, 32'd0);
        bus_write(32'h04, 32'h02);
        push_order(32'h02);
        tick();
        check("req_after_enable", {31'd0, irq_req_o}, 32'd1);
        service_one();

        // Simultaneous 3 and 6, after servicing 4 to set the rotation point.
        bus_write(32'h04, 32'hFF);
        push_order(32'h10);
        pulse_irq(8'h10);
        service_one();
        push_order(32'h48);
        pulse_irq(8'h48);
        service_one();
        service_one();
        repeat (3) tick();

        // Edge and W1C on the same bit in the same cycle: set wins.
        bus_write(32'h04, 32'h00);
        irq_i = 8'h20;
        bus_write(32'h00, 32'h20);
        irq_i = '0;
        read_check("w1c_vs_edge", 32'h00, 32'h20);
        bus_write(32'h00, 32'h20);
        read_check("w1c_alone", 32'h00, 32'h00);

        // Randomized bursts against the reference model.
        for (int r = 0; r < 20; r++) begin
            en  = N'($urandom_range(0, 255));
            set = N'($urandom_range(1, 255));
            serv = en & set;
            bus_write(32'h04, 32'(en));
            push_order(32'(serv));
            pulse_irq(set);
            for (int k = 0; k < $countones(serv); k++) service_one();
            repeat (3) tick();
            check("rand_idle", {31'd0, irq_req_o}, 32'd0);
            read_check("rand_pending", 32'h00, 32'(set & ~en));
            bus_write(32'h00, 32'hFF);
        end

        // Soft reset while active: no return pulse, registers cleared.
        bus_write(32'h04, 32'h02);
        pulse_irq(8'h02);
        wait_req();
        read_check("pre_rst_cause", 32'h08, 32'h8000_0001);
        bus_write(32'h24, 32'h1);
        tick();
        check("soft_rst_req", {31'd0, irq_req_o}, 32'd0);
        check("soft_rst_rdata", read_data_o, 32'd0);
        model_last = 0;
        read_check("soft_rst_pending", 32'h00, 32'd0);
        read_check("soft_rst_enable", 32'h04, 32'd0);
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        repeat (2) tick();
        check("ret_ignored_idle", {31'd0, irq_req_o}, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
